// File: rtl/counter_pkg.sv
// counter_pkg: shared direction type and digit clamp helper for the up/down chain counter.
package counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;
  localparam int CLAMP_BITS = 16;
  function automatic logic [CLAMP_BITS-1:0] digit_clamp(input logic [CLAMP_BITS-1:0] value,
                                                        input logic [CLAMP_BITS-1:0] max);
    return value > max ? max : value;
  endfunction
endpackage

// File: rtl/counter_digit.sv
// counter_digit: one 0..max digit register with load, clear, up/down step and registered wrap pulse.
module counter_digit
  import counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         step,
  input  count_dir_e   dir,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap
);
  logic [W-1:0] value_d, value_q;
  logic         wrap_d, wrap_q;
  assign at_max = value_q == max;
  assign at_min = value_q == '0;
  always_comb begin
    value_d = load ? W'(digit_clamp(CLAMP_BITS'(load_value), CLAMP_BITS'(max))) :
              clr ? '0 :
              !step ? value_q :
              dir == DIR_UP ? (at_max ? '0 : value_q + 1'b1) :
              (at_min ? max : value_q - 1'b1);
    wrap_d  = !load && !clr && step && (dir == DIR_UP ? at_max : at_min);
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  assign value = value_q;
  assign wrap  = wrap_q;
endmodule

// File: rtl/updown_chain_counter.sv
// updown_chain_counter: cascaded up/down digit chain with load, wrap/saturate and end-of-chain pulses.
// Optional synchronous clear port clr is added when COUNTER_CLR_EN is defined.
module updown_chain_counter
  import counter_pkg::*;
#(
  parameter int DIGIT_BITS = 4,
  parameter int NUM_DIGITS = 2,
  parameter logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] DIGIT_MAX = {4'd5, 4'd9},
  parameter bit WRAP = 1'b1
) (
  input  logic                             clk_in,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic                             dir,
  input  logic                             load,
`ifdef COUNTER_CLR_EN
  input  logic                             clr,
`endif
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
  output logic [NUM_DIGITS*DIGIT_BITS-1:0] count,
  output logic [NUM_DIGITS-1:0]            digit_wrap,
  output logic                             max_reached,
  output logic                             min_reached
);
  logic clr_i;
`ifdef COUNTER_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif
  logic [NUM_DIGITS:0]                    carry_up, carry_dn;
  logic [NUM_DIGITS-1:0]                  at_max, at_min, step;
  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0]  value;
  logic                                   active, sat;
  logic                                   max_reached_d, max_reached_q, min_reached_d, min_reached_q;
  count_dir_e                             dir_e;
  assign dir_e       = count_dir_e'(dir);
  assign carry_up[0] = 1'b1;
  assign carry_dn[0] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign carry_up[g+1] = carry_up[g] & at_max[g];
    assign carry_dn[g+1] = carry_dn[g] & at_min[g];
    assign step[g]       = active && !sat && (dir ? carry_up[g] : carry_dn[g]);
    counter_digit #(.W(DIGIT_BITS)) u_digit (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .step       (step[g]),
      .dir        (dir_e),
      .load       (load),
      .clr        (clr_i),
      .load_value (load_value[g*DIGIT_BITS +: DIGIT_BITS]),
      .max        (DIGIT_MAX[g]),
      .value      (value[g]),
      .at_max     (at_max[g]),
      .at_min     (at_min[g]),
      .wrap       (digit_wrap[g])
    );
  end
  // The top digit wraps exactly when the whole chain sits at its end value.
  always_comb begin
    active        = en && !load && !clr_i;
    sat           = !WRAP && (dir ? carry_up[NUM_DIGITS] : carry_dn[NUM_DIGITS]);
    max_reached_d = active && dir && carry_up[NUM_DIGITS];
    min_reached_d = active && !dir && carry_dn[NUM_DIGITS];
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      max_reached_q <= 1'b0;
      min_reached_q <= 1'b0;
    end else begin
      max_reached_q <= max_reached_d;
      min_reached_q <= min_reached_d;
    end
  assign count       = value;
  assign max_reached = max_reached_q;
  assign min_reached = min_reached_q;
endmodule
